// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   Memory-access and writeback pipeline stage with a word-addressed data
//   memory, halfword stores, an LED register, a RUN/HALTED machine and
//   retired/store performance counters.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   stall             freezes all stage state and blocks memory writes
//   Din_*             EX/MEM bundle (controls, ALU result, store data, PCs)
//   status_in         the incoming slot holds a real instruction
//   Dout_RegWrite/Dout_WriteReg/Dout_WBData   registered writeback bundle
//   Dout_PC, status_out                       PC and valid flag of WB slot
//   Led               last value shown by a Show instruction
//   Halt              high once a syscall has retired (HALTED state)
//   RetiredCnt, StoreCnt                      wrapping event counters
//
// Handshake: there is no valid/ready pair here. A slot is accepted on a
// rising edge when status_in=1 and stall=0; stall=1 means the slot is
// presented again on the next edge and nothing in this stage changes.
module mem_wb_stage #(
  parameter int DM_AW = 10,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             Din_SH,
  input  logic             Din_Show,
  input  logic             Din_Syscall,
  input  logic             Din_MemToReg,
  input  logic             Din_MemWrite,
  input  logic             Din_RegWrite,
  input  logic             Din_JAL,
  input  logic [31:0]      Din_LedData,
  input  logic [31:0]      Din_AluResult,
  input  logic [31:0]      Din_R2,
  input  logic [31:0]      Din_PCand4,
  input  logic [31:0]      Din_PC,
  input  logic [4:0]       Din_WriteReg,
  input  logic             status_in,
  output logic             Dout_RegWrite,
  output logic [4:0]       Dout_WriteReg,
  output logic [31:0]      Dout_WBData,
  output logic [31:0]      Dout_PC,
  output logic             status_out,
  output logic [31:0]      Led,
  output logic             Halt,
  output logic [CNT_W-1:0] RetiredCnt,
  output logic [CNT_W-1:0] StoreCnt
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t state;

  logic [31:0]      mem [0:(1<<DM_AW)-1];
  logic [DM_AW-1:0] addr;
  logic [31:0]      rd_word;
  logic [31:0]      wr_word;
  logic [31:0]      wb_data;
  logic             run;
  logic             live;
  logic             commit;
  logic             store_en;
  logic             mem_we;
  logic             unused_addr_bits;

  // Upper address bits are ignored so the memory wraps around; byte
  // offset bit 0 plays no role for word/halfword accesses.
  assign addr             = Din_AluResult[DM_AW+1:2];
  assign unused_addr_bits = ^{Din_AluResult[31:DM_AW+2], Din_AluResult[0]};
  assign rd_word          = mem[addr];

  assign run    = (state == S_RUN);
  // live: the slot is accepted this edge and counts as retired.
  assign live   = status_in & ~stall & run;
  // commit: side effects (memory, LED) are allowed; a syscall slot retires
  // but must not touch memory or the LED.
  assign commit   = live & ~Din_Syscall;
  assign store_en = commit & Din_MemWrite;
  // Gate with rst so that an edge during reset never writes memory.
  assign mem_we   = store_en & rst;

  // Halfword stores merge into the current word (read-modify-write within
  // one cycle thanks to the combinational read).
  always_comb begin
    wr_word = Din_R2;
    if (Din_SH) begin
      if (Din_AluResult[1]) wr_word = {Din_R2[15:0], rd_word[15:0]};
      else                  wr_word = {rd_word[31:16], Din_R2[15:0]};
    end
  end

  always_comb begin
    wb_data = Din_AluResult;
    if (Din_JAL)           wb_data = Din_PCand4;
    else if (Din_MemToReg) wb_data = rd_word;
  end

  // Data memory has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_RUN;
      Dout_RegWrite <= 1'b0;
      Dout_WriteReg <= '0;
      Dout_WBData   <= '0;
      Dout_PC       <= '0;
      status_out    <= 1'b0;
      Led           <= '0;
      RetiredCnt    <= '0;
      StoreCnt      <= '0;
    end else if (!stall) begin
      Dout_WBData   <= wb_data;
      Dout_WriteReg <= Din_WriteReg;
      Dout_PC       <= Din_PC;
      status_out    <= status_in & run;
      // Register $0 is never written.
      Dout_RegWrite <= Din_RegWrite & status_in & run & (|Din_WriteReg);
      if (live)                RetiredCnt <= RetiredCnt + CNT_W'(1);
      if (store_en)            StoreCnt   <= StoreCnt + CNT_W'(1);
      if (commit && Din_Show)  Led        <= Din_LedData;
      if (live && Din_Syscall) state      <= S_HALTED;
    end
  end

  assign Halt = (state == S_HALTED);

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
//   Self-checking bench for mem_wb_stage: directed vector table, hand-written
//   stall / halt / reset sequences, then randomized traffic checked against a
//   transaction-level model (word array plus expected output values).
module tb_mem_wb_stage;

  localparam int DM_AW = 10;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic             stall;
  logic             Din_SH, Din_Show, Din_Syscall, Din_MemToReg;
  logic             Din_MemWrite, Din_RegWrite, Din_JAL;
  logic [31:0]      Din_LedData, Din_AluResult, Din_R2, Din_PCand4, Din_PC;
  logic [4:0]       Din_WriteReg;
  logic             status_in;
  logic             Dout_RegWrite;
  logic [4:0]       Dout_WriteReg;
  logic [31:0]      Dout_WBData, Dout_PC, Led;
  logic             status_out, Halt;
  logic [CNT_W-1:0] RetiredCnt, StoreCnt;

  mem_wb_stage #(.DM_AW(DM_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .Din_SH(Din_SH), .Din_Show(Din_Show), .Din_Syscall(Din_Syscall),
    .Din_MemToReg(Din_MemToReg), .Din_MemWrite(Din_MemWrite),
    .Din_RegWrite(Din_RegWrite), .Din_JAL(Din_JAL),
    .Din_LedData(Din_LedData), .Din_AluResult(Din_AluResult),
    .Din_R2(Din_R2), .Din_PCand4(Din_PCand4), .Din_PC(Din_PC),
    .Din_WriteReg(Din_WriteReg), .status_in(status_in),
    .Dout_RegWrite(Dout_RegWrite), .Dout_WriteReg(Dout_WriteReg),
    .Dout_WBData(Dout_WBData), .Dout_PC(Dout_PC), .status_out(status_out),
    .Led(Led), .Halt(Halt), .RetiredCnt(RetiredCnt), .StoreCnt(StoreCnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- types ----------------
  typedef struct {
    logic        stall, sh, show, sys, m2r, mw, rw, jal, st;
    logic [31:0] led, alu, r2, pc4, pc;
    logic [4:0]  wreg;
  } vec_t;

  typedef struct {
    vec_t        in;
    logic [31:0] exp_wb;
    logic        exp_rw;
    logic        exp_stat;
    logic [31:0] exp_st;
  } tv_t;

  // ---------------- scoreboard / model state ----------------
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] m_mem [0:(1<<DM_AW)-1];
  logic [31:0] m_wb, m_pc, m_led, m_ret, m_st;
  logic [4:0]  m_wreg;
  logic        m_rw, m_stat, m_halt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wb = 0; m_pc = 0; m_led = 0; m_ret = 0; m_st = 0;
    m_wreg = 0; m_rw = 0; m_stat = 0; m_halt = 0;
  endtask

  // One accepted-or-stalled edge, described as a transaction.
  task automatic model_edge();
    int          idx;
    logic [31:0] w;
    logic        run;
    if (!stall) begin
      idx = int'(Din_AluResult[DM_AW+1:2]);
      w   = m_mem[idx];
      run = !m_halt;
      m_wb = Din_JAL ? Din_PCand4 : (Din_MemToReg ? w : Din_AluResult);
      if (status_in && run && !Din_Syscall) begin
        if (Din_MemWrite) begin
          if (!Din_SH)               m_mem[idx] = Din_R2;
          else if (Din_AluResult[1]) m_mem[idx] = {Din_R2[15:0], w[15:0]};
          else                       m_mem[idx] = {w[31:16], Din_R2[15:0]};
          m_st = m_st + 1;
        end
        if (Din_Show) m_led = Din_LedData;
      end
      m_stat = status_in && run;
      m_rw   = Din_RegWrite && status_in && run && (Din_WriteReg != 5'd0);
      m_wreg = Din_WriteReg;
      m_pc   = Din_PC;
      if (status_in && run) m_ret = m_ret + 1;
      if (status_in && Din_Syscall) m_halt = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("wbdata",   Dout_WBData,   m_wb);
    chk("regwrite", Dout_RegWrite, m_rw);
    chk("writereg", Dout_WriteReg, m_wreg);
    chk("pc",       Dout_PC,       m_pc);
    chk("status",   status_out,    m_stat);
    chk("led",      Led,           m_led);
    chk("halt",     Halt,          m_halt);
    chk("retired",  RetiredCnt,    m_ret);
    chk("storecnt", StoreCnt,      m_st);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    stall = v.stall; Din_SH = v.sh; Din_Show = v.show; Din_Syscall = v.sys;
    Din_MemToReg = v.m2r; Din_MemWrite = v.mw; Din_RegWrite = v.rw;
    Din_JAL = v.jal; status_in = v.st; Din_LedData = v.led;
    Din_AluResult = v.alu; Din_R2 = v.r2; Din_PCand4 = v.pc4;
    Din_PC = v.pc; Din_WriteReg = v.wreg;
  endtask

  function automatic vec_t mk(input logic st, mw, sh, m2r, rw, jal,
                              input logic [4:0] wreg,
                              input logic [31:0] alu, r2, pc4);
    vec_t v;
    v.stall = 0; v.show = 0; v.sys = 0; v.led = 0;
    v.st = st; v.mw = mw; v.sh = sh; v.m2r = m2r; v.rw = rw; v.jal = jal;
    v.wreg = wreg; v.alu = alu; v.r2 = r2; v.pc4 = pc4; v.pc = pc4 - 32'd4;
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Assert reset between edges; optionally hold it across one rising edge.
  task automatic do_reset(input bit hold);
    #2 rst = 1'b0;
    #1;
    chk("rst_regwrite", Dout_RegWrite, 0);
    chk("rst_writereg", Dout_WriteReg, 0);
    chk("rst_wbdata",   Dout_WBData,   0);
    chk("rst_pc",       Dout_PC,       0);
    chk("rst_status",   status_out,    0);
    chk("rst_led",      Led,           0);
    chk("rst_halt",     Halt,          0);
    chk("rst_retired",  RetiredCnt,    0);
    chk("rst_storecnt", StoreCnt,      0);
    model_reset();
    if (hold) begin
      @(posedge clk);
      #1;
      check_all();
    end
    #2 rst = 1'b1;
  endtask

  // ---------------- test ----------------
  tv_t         tbl [13];
  vec_t        v;
  logic [31:0] saved_st, saved_ret, r;

  initial begin
    tbl[0]  = '{mk(1,1,0,0,0,0, 5'd0, 32'h10,   32'hDEADBEEF, 32'h1004), 32'h10,       0, 1, 1};
    tbl[1]  = '{mk(1,0,0,1,1,0, 5'd5, 32'h10,   32'h0,        32'h1008), 32'hDEADBEEF, 1, 1, 1};
    tbl[2]  = '{mk(1,1,0,0,0,0, 5'd0, 32'h20,   32'h11223344, 32'h100C), 32'h20,       0, 1, 2};
    tbl[3]  = '{mk(1,1,1,0,0,0, 5'd0, 32'h22,   32'h0000ABCD, 32'h1010), 32'h22,       0, 1, 3};
    tbl[4]  = '{mk(1,0,0,1,1,0, 5'd6, 32'h20,   32'h0,        32'h1014), 32'hABCD3344, 1, 1, 3};
    tbl[5]  = '{mk(1,1,0,0,0,0, 5'd0, 32'h20,   32'h11223344, 32'h1018), 32'h20,       0, 1, 4};
    tbl[6]  = '{mk(1,1,1,0,0,0, 5'd0, 32'h20,   32'h0000ABCD, 32'h101C), 32'h20,       0, 1, 5};
    tbl[7]  = '{mk(1,0,0,1,1,0, 5'd7, 32'h20,   32'h0,        32'h1020), 32'h1122ABCD, 1, 1, 5};
    tbl[8]  = '{mk(1,0,0,0,1,1, 5'd31,32'h55,   32'h0,        32'h3008), 32'h00003008, 1, 1, 5};
    tbl[9]  = '{mk(1,0,0,0,1,0, 5'd0, 32'h77,   32'h0,        32'h1028), 32'h77,       0, 1, 5};
    tbl[10] = '{mk(1,0,0,1,1,0, 5'd8, 32'h1010, 32'h0,        32'h102C), 32'hDEADBEEF, 1, 1, 5};
    tbl[11] = '{mk(0,1,0,0,1,0, 5'd9, 32'h10,   32'h0,        32'h1030), 32'h10,       0, 0, 5};
    tbl[12] = '{mk(1,0,0,1,1,0, 5'd9, 32'h10,   32'h0,        32'h1034), 32'hDEADBEEF, 1, 1, 5};

    // Initial reset
    drive(mk(0,0,0,0,0,0, 5'd0, 32'h0, 32'h0, 32'h4));
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #2 rst = 1'b1;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].in);
      cycle();
      chk($sformatf("tbl%0d_wb", i),   Dout_WBData,   tbl[i].exp_wb);
      chk($sformatf("tbl%0d_rw", i),   Dout_RegWrite, tbl[i].exp_rw);
      chk($sformatf("tbl%0d_stat", i), status_out,    tbl[i].exp_stat);
      chk($sformatf("tbl%0d_st", i),   StoreCnt,      tbl[i].exp_st);
    end

    // Stall holds everything, then a single store
    saved_st = m_st;
    v = mk(1,1,0,0,1,0, 5'd3, 32'h30, 32'h12345678, 32'h2000);
    v.stall = 1;
    drive(v);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_storecnt", StoreCnt, saved_st);
    end
    v.stall = 0;
    drive(v);
    cycle();
    chk("unstall_storecnt", StoreCnt, saved_st + 1);
    drive(mk(1,0,0,1,1,0, 5'd4, 32'h30, 32'h0, 32'h2004));
    cycle();
    chk("stall_store_load", Dout_WBData, 32'h12345678);

    // Show, then syscall (held by stall first), then ignored traffic
    v = mk(1,0,0,0,0,0, 5'd0, 32'h0, 32'h0, 32'h2008);
    v.show = 1; v.led = 32'h5;
    drive(v);
    cycle();
    chk("led_show", Led, 32'h5);
    saved_st = m_st;
    v = mk(1,1,0,0,0,0, 5'd0, 32'h10, 32'h00000BAD, 32'h200C);
    v.sys = 1; v.show = 1; v.led = 32'h77; v.stall = 1;
    drive(v);
    repeat (2) begin
      cycle();
      chk("stalled_syscall_halt", Halt, 0);
    end
    v.stall = 0;
    drive(v);
    cycle();
    chk("syscall_halt",     Halt,       1);
    chk("syscall_status",   status_out, 1);
    chk("syscall_led",      Led,        32'h5);
    chk("syscall_nostore",  StoreCnt,   saved_st);
    saved_ret = m_ret;
    v = mk(1,1,0,0,1,0, 5'd3, 32'h10, 32'h0000F00D, 32'h2010);
    v.show = 1; v.led = 32'h9;
    drive(v);
    repeat (3) begin
      cycle();
      chk("halted_led",     Led,           32'h5);
      chk("halted_status",  status_out,    0);
      chk("halted_rw",      Dout_RegWrite, 0);
      chk("halted_retired", RetiredCnt,    saved_ret);
    end

    // Async reset in HALTED, held over an edge with a store presented
    do_reset(1'b1);
    drive(mk(1,0,0,1,1,0, 5'd2, 32'h10, 32'h0, 32'h2014));
    cycle();
    chk("post_reset_load", Dout_WBData, 32'hDEADBEEF);
    chk("post_reset_halt", Halt, 0);

    // Randomized traffic: preload 16 words, then random slots
    for (int w = 0; w < 16; w++) begin
      drive(mk(1,1,0,0,0,0, 5'd0, 32'(w * 4), $urandom, 32'h3000));
      cycle();
    end
    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      v.stall = ($urandom_range(0, 4) == 0);
      v.st    = ($urandom_range(0, 3) != 0);
      v.sh    = 1'($urandom_range(0, 1));
      v.show  = ($urandom_range(0, 5) == 0);
      v.sys   = ($urandom_range(0, 149) == 0);
      v.m2r   = 1'($urandom_range(0, 1));
      v.mw    = 1'($urandom_range(0, 1));
      v.rw    = 1'($urandom_range(0, 1));
      v.jal   = ($urandom_range(0, 5) == 0);
      v.wreg  = 5'($urandom_range(0, 31));
      v.alu   = {r[31:12], 6'b0, 4'($urandom_range(0, 15)), r[1:0]};
      v.r2    = $urandom;
      v.led   = $urandom;
      v.pc4   = $urandom;
      v.pc    = $urandom;
      drive(v);
      cycle();
      if ($urandom_range(0, 249) == 0) do_reset(1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
